// File: rtl/debug_loader_pkg.sv
// debug_loader_pkg: command bytes, FSM state encoding and default widths
// shared by the debug loader and its word assembler.
// The CHK state exists only when DEBUG_LOADER_CHECKSUM_EN is defined.
package debug_loader_pkg;

   localparam int NBITS_DEFAULT    = 32;
   localparam int CNT_BITS_DEFAULT = 16;
   localparam int ADDR_INC_DEFAULT = 4;

   localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
   localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
   localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNT_HI = 3'd1,
      ST_CNT_LO = 3'd2,
      ST_DATA   = 3'd3,
`ifdef DEBUG_LOADER_CHECKSUM_EN
      ST_CHK    = 3'd4,
`endif
      ST_RUN    = 3'd5
   } state_t;

endpackage

// File: rtl/debug_loader_word_assembler.sv
// debug_loader_word_assembler: packs received bytes MSB first into a word.
// A free-running 2-bit byte counter marks every fourth byte; o_last flags
// that byte combinationally and o_ready is the registered write strobe
// for the word now held in o_word.
module debug_loader_word_assembler
   import debug_loader_pkg::*;
#(
   parameter int W = NBITS_DEFAULT
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_valid,
   input  logic [7:0]   i_byte,
   output logic         o_last,
   output logic         o_ready,
   output logic [W-1:0] o_word
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] shift_q, shift_d;
   logic         ready_q, ready_d;

   // Shift each accepted byte in and strobe ready after the fourth one.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      ready_d = 1'b0;
      if (i_clr) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (i_valid) begin
         cnt_d   = cnt_q + 2'd1;
         shift_d = {shift_q[W-9:0], i_byte};
         ready_d = (cnt_q == 2'd3);
      end
   end

   // Register assembler state; reset drops any partial word.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
         ready_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         ready_q <= ready_d;
      end
   end

   assign o_last  = i_valid && (cnt_q == 2'd3);
   assign o_ready = ready_q;
   assign o_word  = shift_q;

endmodule

// File: rtl/debug_loader.sv
// debug_loader: decodes host command bytes (load / step / run / halt) and
// writes assembled instruction words through the debug memory port while
// holding the pipeline in reset.
// Optional: DEBUG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module debug_loader
   import debug_loader_pkg::*;
#(
   parameter int NBITS    = NBITS_DEFAULT,
   parameter int CNT_BITS = CNT_BITS_DEFAULT,
   parameter int ADDR_INC = ADDR_INC_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   input  logic             i_cpu_halt,
   output logic             o_inst_mem_wr_en,
   output logic [NBITS-1:0] o_inst_mem_addr,
   output logic [NBITS-1:0] o_inst_mem_data,
   output logic             o_cpu_rst,
   output logic             o_step,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   state_t              state_q, state_d;
   logic [7:0]          cnt_hi_q, cnt_hi_d;
   logic [CNT_BITS-1:0] words_left_q, words_left_d;
   logic [NBITS-1:0]    addr_ptr_q, addr_ptr_d;
   logic [NBITS-1:0]    wr_addr_q, wr_addr_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                step_q, step_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
   logic                err_q, err_d;
   logic [7:0]          csum_q, csum_d;
`endif

   logic                load_clr;
   logic                wa_valid;
   logic                wa_last;
   logic [15:0]         cnt_word;
   logic                halt_req;

   assign wa_valid = i_rx_valid && (state_q == ST_DATA);
   assign cnt_word = {cnt_hi_q, i_rx_data};
   assign halt_req = (i_rx_valid && (i_rx_data == CMD_HALT)) || i_cpu_halt;

   debug_loader_word_assembler #(.W(NBITS)) u_word_asm (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (load_clr),
      .i_valid (wa_valid),
      .i_byte  (i_rx_data),
      .o_last  (wa_last),
      .o_ready (o_inst_mem_wr_en),
      .o_word  (o_inst_mem_data)
   );

   // Next-state and registered-output decode for the command FSM.
   always_comb begin
      state_d      = state_q;
      cnt_hi_d     = cnt_hi_q;
      words_left_d = words_left_q;
      addr_ptr_d   = addr_ptr_q;
      wr_addr_d    = wr_addr_q;
      cpu_rst_d    = cpu_rst_q;
      busy_d       = busy_q;
      step_d       = 1'b0;
      done_d       = 1'b0;
      load_clr     = 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      err_d        = 1'b0;
      csum_d       = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     state_d    = ST_CNT_HI;
                     cpu_rst_d  = 1'b0;
                     busy_d     = 1'b1;
                     addr_ptr_d = '0;
                     load_clr   = 1'b1;
`ifdef DEBUG_LOADER_CHECKSUM_EN
                     csum_d     = '0;
`endif
                  end
                  CMD_STEP: begin
                     step_d    = 1'b1;
                     cpu_rst_d = 1'b1;
                  end
                  CMD_RUN: begin
                     state_d   = ST_RUN;
                     step_d    = 1'b1;
                     cpu_rst_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_CNT_HI: begin
            if (i_rx_valid) begin
               cnt_hi_d = i_rx_data;
               state_d  = ST_CNT_LO;
            end
         end
         ST_CNT_LO: begin
            if (i_rx_valid) begin
               if (cnt_word == 16'd0) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  words_left_d = CNT_BITS'(cnt_word);
                  state_d      = ST_DATA;
               end
            end
         end
         ST_DATA: begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
            if (i_rx_valid) csum_d = csum_q ^ i_rx_data;
`endif
            if (wa_last) begin
               // Write address is latched here; the pointer moves on for the next word.
               wr_addr_d    = addr_ptr_q;
               addr_ptr_d   = addr_ptr_q + NBITS'(ADDR_INC);
               words_left_d = words_left_q - CNT_BITS'(1);
               if (words_left_q == CNT_BITS'(1)) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`endif
               end
            end
         end
`ifdef DEBUG_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (i_rx_valid) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               if (i_rx_data == csum_q) done_d = 1'b1;
               else                     err_d  = 1'b1;
            end
         end
`endif
         ST_RUN: begin
            // Halt command and halt retire in the same cycle collapse to one exit.
            if (halt_req) state_d = ST_IDLE;
            else          step_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and registered outputs; reset holds the pipeline in reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q      <= ST_IDLE;
         cnt_hi_q     <= '0;
         words_left_q <= '0;
         addr_ptr_q   <= '0;
         wr_addr_q    <= '0;
         cpu_rst_q    <= 1'b0;
         step_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
         err_q        <= 1'b0;
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_hi_q     <= cnt_hi_d;
         words_left_q <= words_left_d;
         addr_ptr_q   <= addr_ptr_d;
         wr_addr_q    <= wr_addr_d;
         cpu_rst_q    <= cpu_rst_d;
         step_q       <= step_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
         err_q        <= err_d;
         csum_q       <= csum_d;
`endif
      end
   end

   assign o_inst_mem_addr = wr_addr_q;
   assign o_cpu_rst       = cpu_rst_q;
   assign o_step          = step_q;
   assign o_busy          = busy_q;
   assign o_done          = done_q;
`ifdef DEBUG_LOADER_CHECKSUM_EN
   assign o_err           = err_q;
`else
   assign o_err           = 1'b0;
`endif

endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: directed bench for debug_loader with a write scoreboard.
// Honours DEBUG_LOADER_CHECKSUM_EN when the design is built with it.
module tb_debug_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        cpu_halt;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_rst;
   logic        step;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  errors   = 0;
   int  checks   = 0;
   int  n_writes = 0;
   int  n_done   = 0;
   int  n_err    = 0;
   int  high     = 0;

   always #5 clk = ~clk;

   debug_loader dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_rx_data        (rx_data),
      .i_rx_valid       (rx_valid),
      .i_cpu_halt       (cpu_halt),
      .o_inst_mem_wr_en (wr_en),
      .o_inst_mem_addr  (wr_addr),
      .o_inst_mem_data  (wr_data),
      .o_cpu_rst        (cpu_rst),
      .o_step           (step),
      .o_busy           (busy),
      .o_done           (done),
      .o_err            (err)
   );

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the edge and any
   // write is checked against the head of the scoreboard.
   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (wr_en) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            chk_bit("unexpected_write", wr_en, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk_word("wr_addr", wr_addr, e.addr);
            chk_word("wr_data", wr_data, e.data);
         end
      end
      if (done) n_done++;
      if (err)  n_err++;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   initial begin
      logic [7:0] stream [10];
      rst      = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      cpu_halt = 1'b0;

      // Reset state
      tick();
      tick();
      chk_bit("rst_cpu_rst", cpu_rst, 1'b0);
      chk_bit("rst_step", step, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      chk_bit("rst_err", err, 1'b0);
      chk_bit("rst_wr_en", wr_en, 1'b0);
      chk_word("rst_addr", wr_addr, 32'h0);
      chk_word("rst_data", wr_data, 32'h0);
      rst = 1'b1;
      tick();

      // Unknown byte and halt in IDLE are ignored
      send(8'h00);
      send(8'h48);
      chk_bit("ignored_step", step, 1'b0);
      chk_bit("ignored_busy", busy, 1'b0);

      // Single step
      send(8'h53);
      chk_bit("step_pulse", step, 1'b1);
      chk_bit("step_cpu_rst", cpu_rst, 1'b1);
      tick();
      chk_bit("step_drop", step, 1'b0);
      tick();
      chk_bit("step_stays_low", step, 1'b0);

      // Two-word load, back-to-back bytes
      exp_q.push_back('{addr: 32'h0, data: 32'h20080005});
      exp_q.push_back('{addr: 32'h4, data: 32'hAC010004});
      stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
      send(8'h4C);
      chk_bit("load_busy_start", busy, 1'b1);
      chk_bit("load_cpu_rst", cpu_rst, 1'b0);
      for (int i = 0; i < 10; i++) begin
         send(stream[i]);
         if (i < 9) chk_bit("load_busy_mid", busy, 1'b1);
      end
      chk_bit("load2_last_wr_en", wr_en, 1'b1);
`ifdef DEBUG_LOADER_CHECKSUM_EN
      chk_bit("load2_no_done_before_csum", done, 1'b0);
      send(8'h84);
`endif
      chk_bit("load2_done", done, 1'b1);
      chk_bit("load2_busy_end", busy, 1'b0);
      chk_bit("load2_cpu_rst_held", cpu_rst, 1'b0);
      tick();
      chk_bit("load2_done_one_cycle", done, 1'b0);
      chk_word("load2_queue_empty", exp_q.size(), 32'd0);
      chk_word("load2_writes", n_writes, 32'd2);

      // Zero-length load
      send(8'h4C);
      send(8'h00);
      send(8'h00);
      chk_bit("load0_done", done, 1'b1);
      chk_bit("load0_busy", busy, 1'b0);
      tick();
      chk_bit("load0_done_one_cycle", done, 1'b0);
      chk_word("load0_no_writes", n_writes, 32'd2);

      // Continuous run stopped by i_cpu_halt after 10 cycles
      send(8'h43);
      high = step ? 1 : 0;
      send(8'h4C);
      chk_bit("run_ignores_load", busy, 1'b0);
      if (step) high++;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (step) high++;
      end
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      chk_bit("run_halt_drop", step, 1'b0);
      chk_word("run_high_cycles", high, 32'd10);
      tick();
      chk_bit("run_stays_stopped", step, 1'b0);

      // Run stopped by 'H' together with i_cpu_halt: a single exit
      send(8'h43);
      tick();
      chk_bit("run2_step", step, 1'b1);
      cpu_halt = 1'b1;
      send(8'h48);
      cpu_halt = 1'b0;
      chk_bit("run2_halt_drop", step, 1'b0);
      send(8'h53);
      chk_bit("run2_idle_step", step, 1'b1);
      tick();
      chk_bit("run2_idle_step_drop", step, 1'b0);

      // Reset after two data bytes, then a clean one-word load
      send(8'h4C);
      send(8'h00);
      send(8'h01);
      send(8'hDE);
      send(8'hAD);
      rst      = 1'b0;
      rx_data  = 8'h53;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rst      = 1'b1;
      chk_bit("midrst_step_ignored", step, 1'b0);
      chk_bit("midrst_busy", busy, 1'b0);
      chk_bit("midrst_cpu_rst", cpu_rst, 1'b0);
      chk_bit("midrst_wr_en", wr_en, 1'b0);
      tick();
      exp_q.push_back('{addr: 32'h0, data: 32'hCAFEBABE});
      send(8'h4C);
      send(8'h00);
      send(8'h01);
      send(8'hCA);
      send(8'hFE);
      send(8'hBA);
      send(8'hBE);
`ifdef DEBUG_LOADER_CHECKSUM_EN
      send(8'h30);
`endif
      chk_bit("reload_done", done, 1'b1);
      tick();
      chk_word("reload_queue_empty", exp_q.size(), 32'd0);
      chk_word("reload_writes", n_writes, 32'd3);

`ifdef DEBUG_LOADER_CHECKSUM_EN
      // Checksum match
      exp_q.push_back('{addr: 32'h0, data: 32'h11223344});
      send(8'h4C);
      send(8'h00);
      send(8'h01);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      chk_bit("csum_ok_write_no_done", done, 1'b0);
      chk_bit("csum_ok_busy_in_chk", busy, 1'b1);
      send(8'h44);
      chk_bit("csum_ok_done", done, 1'b1);
      chk_bit("csum_ok_err", err, 1'b0);
      chk_bit("csum_ok_cpu_rst", cpu_rst, 1'b0);
      chk_bit("csum_ok_busy", busy, 1'b0);
      tick();

      // Checksum mismatch
      exp_q.push_back('{addr: 32'h0, data: 32'h11223344});
      send(8'h4C);
      send(8'h00);
      send(8'h01);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      send(8'h45);
      chk_bit("csum_bad_err", err, 1'b1);
      chk_bit("csum_bad_no_done", done, 1'b0);
      chk_bit("csum_bad_cpu_rst", cpu_rst, 1'b0);
      tick();
      chk_bit("csum_bad_err_one_cycle", err, 1'b0);
      chk_word("csum_queue_empty", exp_q.size(), 32'd0);
      chk_word("csum_err_count", n_err, 32'd1);
`else
      chk_word("no_err_pulses", n_err, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
